// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte-stream
// requesters; a grant is held for a whole burst, one byte per tx_done_tick.
module uart_tx_arbiter #(
    parameter int NREQ     = 3,
    parameter int LOCK_TMO = 1024,
    parameter int TW       = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                lock_err,
    output logic                tx_start,
    output logic [7:0]          tx_din,
    input  logic                tx_done_tick
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TMO - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   ptr, ptr_next;
    logic [PW-1:0]   owner, owner_next;
    logic [PW-1:0]   pick;
    logic            pick_valid;
    logic            last, last_next;
    logic [TW-1:0]   cnt, cnt_next;
    logic [NREQ-1:0] ack_next, grant_next;
    logic            busy_next, lock_err_next, tx_start_next;
    logic [7:0]      tx_din_next;
    logic [7:0]      req_byte [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign req_byte[g] = req_data[8*g +: 8];
    end

    function automatic logic [PW-1:0] succ(input logic [PW-1:0] idx);
        int nxt;
        nxt = int'(idx) + 1;
        if (nxt >= NREQ) nxt = 0;
        return PW'(nxt);
    endfunction

    // First pending requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int cand;
        pick       = '0;
        pick_valid = 1'b0;
        cand       = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!pick_valid && req[PW'(cand)]) begin
                pick_valid = 1'b1;
                pick       = PW'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            last     <= 1'b0;
            cnt      <= '0;
            ack      <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            lock_err <= 1'b0;
            tx_start <= 1'b0;
            tx_din   <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            owner    <= owner_next;
            last     <= last_next;
            cnt      <= cnt_next;
            ack      <= ack_next;
            grant    <= grant_next;
            busy     <= busy_next;
            lock_err <= lock_err_next;
            tx_start <= tx_start_next;
            tx_din   <= tx_din_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (pick_valid) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (tx_done_tick) begin
                    if (last)            state_next = IDLE;
                    else if (req[owner]) state_next = ISSUE;
                    else                 state_next = HOLD;
                end
            end
            HOLD: begin
                if (req[owner])            state_next = ISSUE;
                else if (cnt == TMO_LAST)  state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs are computed from the upcoming state so that they
    // line up with it, e.g. tx_start and ack are high exactly during ISSUE.
    always_comb begin
        ptr_next      = ptr;
        owner_next    = owner;
        last_next     = last;
        cnt_next      = cnt;
        tx_din_next   = tx_din;
        lock_err_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_next  = pick;
                    tx_din_next = req_byte[pick];
                    last_next   = req_last[pick];
                end
            end
            WAIT: begin
                if (tx_done_tick) begin
                    if (last) begin
                        ptr_next = succ(owner);
                    end else if (req[owner]) begin
                        tx_din_next = req_byte[owner];
                        last_next   = req_last[owner];
                    end else begin
                        cnt_next = '0;
                    end
                end
            end
            HOLD: begin
                if (req[owner]) begin
                    tx_din_next = req_byte[owner];
                    last_next   = req_last[owner];
                end else if (cnt == TMO_LAST) begin
                    lock_err_next = 1'b1;
                    ptr_next      = succ(owner);
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: ;
        endcase

        tx_start_next = (state_next == ISSUE);
        busy_next     = (state_next != IDLE);
        ack_next      = '0;
        grant_next    = '0;
        ack_next[owner_next]   = tx_start_next;
        grant_next[owner_next] = busy_next;
    end

endmodule
